// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2,
    HOLD  = 2'd3
  } if_state_e;

  typedef enum logic [1:0] {
    PC_HOLD  = 2'd0,
    PC_INC   = 2'd1,
    PC_REDIR = 2'd2,
    PC_SAVED = 2'd3
  } pc_sel_e;

  localparam int IF_ID_W   = 64;
  localparam int NPC_MSB   = 63;
  localparam int NPC_LSB   = 32;
  localparam int INSTR_MSB = 31;
  localparam int INSTR_LSB = 0;

  localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/if_pc_unit.sv
// Program counter register and next-PC selection for the fetch stage.
module if_pc_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] saved_target,
  output logic [31:0] pc,
  output logic [31:0] pc_inc
);

  logic [31:0] pc_next;

  // Modulo-2^32 increment: the top word wraps silently to zero.
  assign pc_inc = pc + 32'(PC_STEP);

  always_comb begin
    pc_next = pc;
    case (pc_sel)
      PC_INC:   pc_next = pc_inc;
      PC_REDIR: pc_next = redirect_pc;
      PC_SAVED: pc_next = saved_target;
      default:  pc_next = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) pc <= RESET_PC;
    else       pc <= pc_next;
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, imem req/ready fetch FSM and IF/ID bundle register.
// Optional build macro IF_PERF_CNT_EN adds fetch_cnt / bubble_cnt counters.
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               imem_ready,
  output logic [IF_ID_W-1:0] if_id_bundle,
  output logic               if_id_valid,
  output logic [1:0]         state_dbg
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        bubble_cnt
`endif
);

  // Handshake: a fetch completes on any rising edge where imem_req && imem_ready;
  // imem_addr is held constant from the rise of imem_req until that edge.

  if_state_e   state, state_next;
  pc_sel_e     pc_sel;
  logic [31:0] pc, pc_inc;
  logic [31:0] saved_target, saved_next;
  logic [31:0] hold_buf, hold_next;
  logic [31:0] redir_aligned;
  logic [31:0] instr_src;
  logic        load_valid, load_bubble;

  assign redir_aligned = redirect_pc & ~32'h3;
  assign imem_req      = (state == FETCH) || (state == DROP);
  assign imem_addr     = pc;
  assign state_dbg     = state;
  assign instr_src     = (state == HOLD) ? hold_buf : imem_rdata;

  if_pc_unit #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc (
    .clk          (clk),
    .reset        (reset),
    .pc_sel       (pc_sel),
    .redirect_pc  (redir_aligned),
    .saved_target (saved_target),
    .pc           (pc),
    .pc_inc       (pc_inc)
  );

  always_comb begin
    state_next  = state;
    pc_sel      = PC_HOLD;
    saved_next  = saved_target;
    hold_next   = hold_buf;
    load_valid  = 1'b0;
    load_bubble = 1'b0;
    case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        if (redirect) begin
          load_bubble = 1'b1;
          if (imem_ready) begin
            pc_sel = PC_REDIR;
          end else begin
            // Request stays on the bus with its old address until it is accepted.
            saved_next = redir_aligned;
            state_next = DROP;
          end
        end else if (imem_ready) begin
          if (!stall) begin
            load_valid = 1'b1;
            pc_sel     = PC_INC;
          end else begin
            hold_next  = imem_rdata;
            state_next = HOLD;
          end
        end else if (!stall) begin
          load_bubble = 1'b1;
        end
      end
      DROP: begin
        if (redirect) saved_next = redir_aligned;
        if (imem_ready) begin
          pc_sel     = redirect ? PC_REDIR : PC_SAVED;
          state_next = FETCH;
        end
      end
      HOLD: begin
        if (redirect) begin
          load_bubble = 1'b1;
          pc_sel      = PC_REDIR;
          state_next  = FETCH;
        end else if (!stall) begin
          load_valid = 1'b1;
          pc_sel     = PC_INC;
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      saved_target <= 32'h0;
      hold_buf     <= 32'h0;
      if_id_bundle <= '0;
      if_id_valid  <= 1'b0;
    end else begin
      state        <= state_next;
      saved_target <= saved_next;
      hold_buf     <= hold_next;
      if (load_valid) begin
        if_id_bundle[NPC_MSB:NPC_LSB]     <= pc_inc;
        if_id_bundle[INSTR_MSB:INSTR_LSB] <= instr_src;
        if_id_valid                       <= 1'b1;
      end else if (load_bubble) begin
        if_id_bundle[NPC_MSB:NPC_LSB]     <= 32'h0;
        if_id_bundle[INSTR_MSB:INSTR_LSB] <= NOP_INSTR;
        if_id_valid                       <= 1'b0;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt  <= 32'h0;
      bubble_cnt <= 32'h0;
    end else begin
      if (load_valid)  fetch_cnt  <= fetch_cnt + 32'h1;
      if (load_bubble) bubble_cnt <= bubble_cnt + 32'h1;
    end
  end
`endif

endmodule
